// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: turns received commands into trigger/sampler configuration,
// control pulses and multi-byte replies. Define CMD_METADATA_EN to add the 0x04 metadata reply.
module sump_cmd_decoder #(
   parameter int unsigned WORD_BITS = 8,
   parameter int unsigned CMD_WORDS = 5,
   parameter int unsigned STAGES    = 4,
   parameter logic [31:0] MEM_DEPTH = 32'd4096
) (
   input  logic                           clk_i,
   input  logic                           rst_in,
   input  logic [CMD_WORDS*WORD_BITS-1:0] cmd_i,
   input  logic                           stb_i,
   output logic [STAGES*32-1:0]           trg_mask_o,
   output logic [STAGES*32-1:0]           trg_val_o,
   output logic [STAGES*32-1:0]           trg_cfg_o,
   output logic [23:0]                    div_o,
   output logic [15:0]                    read_cnt_o,
   output logic [15:0]                    delay_cnt_o,
   output logic [7:0]                     flags_o,
   output logic                           arm_o,
   output logic                           sw_rst_o,
   output logic [WORD_BITS-1:0]           tx_data_o,
   output logic                           tx_stb_o,
   input  logic                           tx_ack_i
);

   if (WORD_BITS != 8 || CMD_WORDS != 5 || STAGES < 1 || STAGES > 4 || MEM_DEPTH == 32'd0) begin : g_param_check
      $error("sump_cmd_decoder: unsupported parameter set");
   end

   typedef enum logic {ST_IDLE, ST_SEND} state_e;

   logic [7:0]  op;
   logic [31:0] arg;
   assign op  = cmd_i[7:0];
   assign arg = cmd_i[39:8];

   logic [STAGES*32-1:0] mask_q, val_q, cfg_q;
   logic [23:0]          div_q;
   logic [15:0]          read_cnt_q, delay_cnt_q;
   logic [7:0]           flags_q;
   logic                 arm_q, sw_rst_q;

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         mask_q      <= '0;
         val_q       <= '0;
         cfg_q       <= '0;
         div_q       <= '0;
         read_cnt_q  <= '0;
         delay_cnt_q <= '0;
         flags_q     <= '0;
         arm_q       <= 1'b0;
         sw_rst_q    <= 1'b0;
      end else begin
         arm_q    <= stb_i && (op == 8'h01);
         sw_rst_q <= stb_i && (op == 8'h00);
         if (stb_i) begin
            // 0xC0..0xCE: stage in op[3:2], register kind in op[1:0]; kind 3 is undefined
            if (op[7:4] == 4'hC && op[1:0] != 2'b11) begin
               for (int unsigned s = 0; s < STAGES; s++) begin
                  if (op[3:2] == 2'(s)) begin
                     case (op[1:0])
                        2'b00:   mask_q[32*s +: 32] <= arg;
                        2'b01:   val_q[32*s +: 32]  <= arg;
                        default: cfg_q[32*s +: 32]  <= arg;
                     endcase
                  end
               end
            end
            case (op)
               8'h80: div_q <= arg[23:0];
               8'h81: begin
                  read_cnt_q  <= arg[15:0];
                  delay_cnt_q <= arg[31:16];
               end
               8'h82: flags_q <= arg[7:0];
               default: ;
            endcase
         end
      end
   end

   state_e               state_q, state_d;
   logic [3:0]           idx_q, idx_d, rom_idx, last_idx;
   logic [WORD_BITS-1:0] data_q, data_d;
   logic [7:0]           rom_byte;
   logic                 start_id, abort;

   assign start_id = stb_i && (op == 8'h02);
   assign abort    = stb_i && (op == 8'h00);
   assign rom_idx  = (state_q == ST_IDLE) ? 4'd0 : idx_q + 4'd1;

`ifdef CMD_METADATA_EN
   logic meta_q, meta_d, rom_meta, start_meta;
   assign start_meta = stb_i && (op == 8'h04);
   assign rom_meta   = (state_q == ST_IDLE) ? start_meta : meta_q;
   assign last_idx   = meta_q ? 4'd12 : 4'd3;

   always_comb begin
      rom_byte = 8'h00;
      if (rom_meta) begin
         case (rom_idx)
            4'd0:    rom_byte = 8'h01;
            4'd1:    rom_byte = 8'h6C;
            4'd2:    rom_byte = 8'h6F;
            4'd3:    rom_byte = 8'h67;
            4'd4:    rom_byte = 8'h49;
            4'd5:    rom_byte = 8'h50;
            4'd7:    rom_byte = 8'h21;
            4'd8:    rom_byte = MEM_DEPTH[31:24];
            4'd9:    rom_byte = MEM_DEPTH[23:16];
            4'd10:   rom_byte = MEM_DEPTH[15:8];
            4'd11:   rom_byte = MEM_DEPTH[7:0];
            default: rom_byte = 8'h00;
         endcase
      end else begin
         case (rom_idx)
            4'd0:    rom_byte = 8'h31;
            4'd1:    rom_byte = 8'h41;
            4'd2:    rom_byte = 8'h4C;
            4'd3:    rom_byte = 8'h53;
            default: rom_byte = 8'h00;
         endcase
      end
   end
`else
   assign last_idx = 4'd3;

   always_comb begin
      case (rom_idx)
         4'd0:    rom_byte = 8'h31;
         4'd1:    rom_byte = 8'h41;
         4'd2:    rom_byte = 8'h4C;
         4'd3:    rom_byte = 8'h53;
         default: rom_byte = 8'h00;
      endcase
   end
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
`ifdef CMD_METADATA_EN
      meta_d  = meta_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start_id) begin
               state_d = ST_SEND;
               idx_d   = 4'd0;
               data_d  = WORD_BITS'(rom_byte);
`ifdef CMD_METADATA_EN
               meta_d  = 1'b0;
            end else if (start_meta) begin
               state_d = ST_SEND;
               idx_d   = 4'd0;
               data_d  = WORD_BITS'(rom_byte);
               meta_d  = 1'b1;
`endif
            end
         end
         ST_SEND: begin
            // soft reset wins over a same-cycle ack; repeated reply requests are simply not looked at here
            if (abort) begin
               state_d = ST_IDLE;
            end else if (tx_ack_i) begin
               if (idx_q == last_idx) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  data_d = WORD_BITS'(rom_byte);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
`ifdef CMD_METADATA_EN
         meta_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
`ifdef CMD_METADATA_EN
         meta_q  <= meta_d;
`endif
      end
   end

   assign trg_mask_o  = mask_q;
   assign trg_val_o   = val_q;
   assign trg_cfg_o   = cfg_q;
   assign div_o       = div_q;
   assign read_cnt_o  = read_cnt_q;
   assign delay_cnt_o = delay_cnt_q;
   assign flags_o     = flags_q;
   assign arm_o       = arm_q;
   assign sw_rst_o    = sw_rst_q;
   assign tx_data_o   = data_q;
   assign tx_stb_o    = (state_q == ST_SEND);

endmodule

// File: doc/sump_cmd_decoder.md
Name: sump_cmd_decoder

Overview:
Consumes assembled commands from the async UART receiver (CMD_WORDS×WORD_BITS word plus one-cycle strobe). Decodes SUMP opcodes into configuration registers and control pulses for the trigger, sampler and memory stages. Sequences multi-byte replies (ID string) to the UART transmitter over a strobe/ack handshake.

Parameters:
WORD_BITS, 8, bits per UART word
CMD_WORDS, 5, words per command; cmd_i width = CMD_WORDS*WORD_BITS (must be 5 for SUMP)
STAGES, 4, number of trigger stages (1..4)
MEM_DEPTH, 32'd4096, sample memory depth reported in metadata

Ports:
clk_i  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
cmd_i  in  CMD_WORDS*WORD_BITS  command; [7:0] opcode, [39:8] argument, first argument byte in [15:8]
stb_i  in  1  one-cycle pulse, cmd_i valid
trg_mask_o  out  STAGES*32  per-stage trigger mask, stage s at [32s+31:32s]
trg_val_o  out  STAGES*32  per-stage trigger value
trg_cfg_o  out  STAGES*32  per-stage trigger config
div_o  out  24  sample clock divider
read_cnt_o  out  16  read count
delay_cnt_o  out  16  delay count
flags_o  out  8  flags byte
arm_o  out  1  one-cycle pulse, run/arm
sw_rst_o  out  1  one-cycle pulse, SUMP soft reset
tx_data_o  out  WORD_BITS  reply byte
tx_stb_o  out  1  reply byte valid, held until ack
tx_ack_i  in  1  transmitter accepted tx_data_o

Behaviour:
- Reset (rst_in=0, async): all registers 0, arm_o=sw_rst_o=tx_stb_o=0, tx_data_o=0, FSM IDLE.
- Decode only on stb_i=1; latency 1 cycle: registers/pulses valid the cycle after stb_i.
- Short opcodes: 0x00 -> sw_rst_o pulse; 0x01 -> arm_o pulse; 0x02 -> start ID reply; 0x11/0x13 (XON/XOFF) ignored.
- Long opcodes: 0xC0|s<<2 mask, 0xC1|s<<2 value, 0xC2|s<<2 config, with s=opcode[3:2]; argument stored to stage s; s>=STAGES ignored.
- 0x80: div_o <= arg[23:0]. 0x81: read_cnt_o <= arg[15:0], delay_cnt_o <= arg[31:16]. 0x82: flags_o <= arg[7:0].
- Any other opcode: no effect.
- sw_rst_o does not clear registers inside this block; only rst_in does.
- Reply FSM: IDLE -> SEND (load byte idx 0, tx_stb_o=1) -> on tx_ack_i, advance idx; after last byte acked -> IDLE, tx_stb_o=0 same cycle as ack processed.
- ID reply bytes in order: 0x31 '1', 0x41 'A', 0x4C 'L', 0x53 'S'.
- tx_data_o stable while tx_stb_o=1 and tx_ack_i=0.
- Reply request (0x02) while FSM not IDLE: dropped; register writes and pulses still processed during SEND.
- 0x00 while in SEND: sw_rst_o pulse and FSM aborts to IDLE, tx_stb_o=0 next cycle.
- tx_ack_i while tx_stb_o=0: ignored.
- stb_i and tx_ack_i same cycle: both processed independently.

Optional Feature:
CMD_METADATA_EN defined: opcode 0x04 starts metadata reply via same FSM: 0x01,"logIP",0x00, 0x21, MEM_DEPTH big-endian 4 bytes, 0x00 (13 bytes). Same drop/abort rules as ID.
Undefined: 0x04 ignored like any unknown opcode; no metadata ROM synthesized.

Test Plan:
- Reset, then stb_i with cmd_i=40'h00_0000_0002 -> tx_stb_o rises next cycle; with ack each cycle, bytes 0x31,0x41,0x4C,0x53 then tx_stb_o=0.
- cmd 0xC4 arg 0xDEADBEEF -> trg_mask_o[63:32]=32'hDEADBEEF one cycle after stb_i; other stages 0.
- cmd 0x81 arg 0x0010_0020 -> read_cnt_o=16'h0020, delay_cnt_o=16'h0010; cmd 0x80 arg 0xFF123456 -> div_o=24'h123456.
- STAGES=2, cmd 0xC8 arg 0x1 -> no output change; cmd 0x01 -> arm_o single-cycle pulse.
- ID reply with tx_ack_i held low 10 cycles -> tx_data_o=0x31 stable; second 0x02 mid-reply dropped; 0x00 mid-reply -> sw_rst_o pulse, tx_stb_o=0 next cycle.
- CMD_METADATA_EN, cmd 0x04, MEM_DEPTH=4096 -> 13 bytes ending 0x21,0x00,0x00,0x10,0x00,0x00; without macro -> tx_stb_o stays 0.
